// File: rtl/exec_datapath_if.sv
// Issue bus from the decoder plus the valid/ack data-memory port of the execute datapath.
// master = decoder/memory side, slave = exec_datapath.
interface exec_datapath_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      issue_valid;
  logic                      issue_ready;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      reg_wen;
  logic                      alu_src;
  logic [DATA_WIDTH-1:0]     imm;
  logic [3:0]                alu_ctrl;
  logic                      mem_read;
  logic                      mem_write;
  logic [1:0]                data_type;
  logic                      load_unsigned;
  logic                      jump_sel;
  logic [DATA_WIDTH-1:0]     new_pc;

  logic                      mem_req;
  logic                      mem_we;
  logic [DATA_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      mem_ack;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport master (
    output issue_valid, rs1, rs2, rd, reg_wen, alu_src, imm, alu_ctrl,
           mem_read, mem_write, data_type, load_unsigned, jump_sel, new_pc,
           mem_ack, mem_rdata,
    input  issue_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  issue_valid, rs1, rs2, rd, reg_wen, alu_src, imm, alu_ctrl,
           mem_read, mem_write, data_type, load_unsigned, jump_sel, new_pc,
           mem_ack, mem_rdata,
    output issue_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/exec_datapath.sv
// Register file + single registered EX stage (ALU, load/store, write-back bypass).
// ALU ops complete in 1 cycle; memory ops hold EX (issue_ready low) until mem_ack.
module exec_datapath #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int A0_INDEX       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  exec_datapath_if.slave        bus,
  output logic                  eq,
  output logic [DATA_WIDTH-1:0] jalr_target,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] a0
);
  localparam int NREGS = 2 ** REG_ADDR_WIDTH;
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int SHW   = $clog2(DATA_WIDTH);

  localparam logic [1:0] DT_BYTE = 2'b01;
  localparam logic [1:0] DT_HALF = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_op1;
  logic [DATA_WIDTH-1:0]     ex_op2;
  logic [DATA_WIDTH-1:0]     ex_rs2d;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_wen;
  logic [3:0]                ex_alu_ctrl;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [1:0]                ex_data_type;
  logic                      ex_load_unsigned;
  logic                      ex_jump_sel;
  logic [DATA_WIDTH-1:0]     ex_new_pc;

  logic                  is_mem, is_byte, is_half, addr_bad, ex_done, accept, wb_en;
  logic [DATA_WIDTH-1:0] addr, alu_res, wb_data, rd1, rd2, op2;
  logic [OFFW-1:0]       off;
  logic [SHW-1:0]        shamt, ld_pad;
  logic [BYTES-1:0]      size_mask;
  logic [DATA_WIDTH-1:0] ld_shift, ld_left, ld_zext, ld_sext, load_data;

  assign is_mem   = ex_mem_read | ex_mem_write;
  assign is_byte  = (ex_data_type == DT_BYTE);
  assign is_half  = (ex_data_type == DT_HALF);
  assign addr     = ex_op1 + ex_imm;
  assign off      = addr[OFFW-1:0];
  assign addr_bad = (is_half && addr[0]) || (!is_byte && !is_half && (addr[1:0] != 2'b00));

  // A misaligned access never reaches memory; it retires in its first EX cycle.
  assign misaligned      = ex_valid && is_mem && addr_bad;
  assign bus.mem_req     = ex_valid && is_mem && !addr_bad;
  assign bus.mem_we      = bus.mem_req && ex_mem_write;
  assign bus.mem_addr    = addr;
  assign size_mask       = is_byte ? BYTES'(1) : (is_half ? BYTES'(3) : BYTES'(15));
  assign bus.mem_be      = bus.mem_req ? (size_mask << off) : '0;
  assign bus.mem_wdata   = is_byte ? {BYTES{ex_rs2d[7:0]}} :
                           (is_half ? {(BYTES/2){ex_rs2d[15:0]}} : {(BYTES/4){ex_rs2d[31:0]}});

  assign ex_done         = ex_valid && (!is_mem || bus.mem_ack || misaligned);
  assign bus.issue_ready = !ex_valid || ex_done;
  assign accept          = bus.issue_valid && bus.issue_ready;

  // Move the addressed lanes to the top, then shift back down to extend.
  always_comb begin
    ld_shift  = bus.mem_rdata >> {off, 3'b000};
    ld_pad    = is_byte ? SHW'(DATA_WIDTH - 8) :
                (is_half ? SHW'(DATA_WIDTH - 16) : SHW'(DATA_WIDTH - 32));
    ld_left   = ld_shift << ld_pad;
    ld_zext   = ld_left >> ld_pad;
    ld_sext   = $signed(ld_left) >>> ld_pad;
    load_data = ex_load_unsigned ? ld_zext : ld_sext;
  end

  assign shamt = ex_op2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ex_alu_ctrl)
      4'b0000: alu_res = ex_op1 + ex_op2;
      4'b0001: alu_res = ex_op1 - ex_op2;
      4'b0010: alu_res = ex_op1 & ex_op2;
      4'b0011: alu_res = ex_op1 | ex_op2;
      4'b0100: alu_res = ex_op1 ^ ex_op2;
      4'b0101: alu_res = ex_op1 << shamt;
      4'b0110: alu_res = ex_op1 >> shamt;
      4'b0111: alu_res = $signed(ex_op1) >>> shamt;
      4'b1000: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_op1) < $signed(ex_op2))};
      4'b1001: alu_res = {{(DATA_WIDTH-1){1'b0}}, (ex_op1 < ex_op2)};
      4'b1010: alu_res = ex_op2;
      default: alu_res = '0;
    endcase
  end

  assign wb_en   = ex_done && ex_reg_wen && !misaligned && !ex_mem_write && (ex_rd != '0);
  assign wb_data = ex_mem_read ? load_data : (ex_jump_sel ? ex_new_pc : alu_res);

  always_comb begin
    rd1 = regs[bus.rs1];
    rd2 = regs[bus.rs2];
    if (wb_en && (ex_rd == bus.rs1)) rd1 = wb_data;
    if (wb_en && (ex_rd == bus.rs2)) rd2 = wb_data;
    if (bus.rs1 == '0) rd1 = '0;
    if (bus.rs2 == '0) rd2 = '0;
  end

  assign op2 = bus.alu_src ? bus.imm : rd2;
  assign a0  = regs[A0_INDEX];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[ex_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid         <= 1'b0;
      ex_op1           <= '0;
      ex_op2           <= '0;
      ex_rs2d          <= '0;
      ex_imm           <= '0;
      ex_rd            <= '0;
      ex_reg_wen       <= 1'b0;
      ex_alu_ctrl      <= '0;
      ex_mem_read      <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_data_type     <= '0;
      ex_load_unsigned <= 1'b0;
      ex_jump_sel      <= 1'b0;
      ex_new_pc        <= '0;
      eq               <= 1'b0;
      jalr_target      <= '0;
    end else if (accept) begin
      ex_valid         <= 1'b1;
      ex_op1           <= rd1;
      ex_op2           <= op2;
      ex_rs2d          <= rd2;
      ex_imm           <= bus.imm;
      ex_rd            <= bus.rd;
      ex_reg_wen       <= bus.reg_wen;
      ex_alu_ctrl      <= bus.alu_ctrl;
      ex_mem_read      <= bus.mem_read;
      ex_mem_write     <= bus.mem_write;
      ex_data_type     <= bus.data_type;
      ex_load_unsigned <= bus.load_unsigned;
      ex_jump_sel      <= bus.jump_sel;
      ex_new_pc        <= bus.new_pc;
      eq               <= (rd1 == op2);
      jalr_target      <= (rd1 + bus.imm) & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
    end else if (ex_done) begin
      ex_valid         <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_datapath.sv
// Directed self-checking bench for exec_datapath; register contents observed by copying into a0 (x10).
module tb_exec_datapath;
  localparam logic [3:0] ADD = 4'b0000;

  logic        clk;
  logic        rst;
  logic        eq;
  logic        misaligned;
  logic [31:0] jalr_target;
  logic [31:0] a0;
  int          checks;
  int          failures;

  exec_datapath_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  exec_datapath #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .A0_INDEX(10)) dut (
    .clk(clk), .rst(rst), .bus(bus), .eq(eq),
    .jalr_target(jalr_target), .misaligned(misaligned), .a0(a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd_i, input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                       input logic src_i, input logic [31:0] imm_i, input logic [3:0] ctl_i,
                       input logic mr_i, input logic mw_i, input logic [1:0] dt_i,
                       input logic lu_i, input logic js_i, input logic [31:0] pc_i);
    bus.issue_valid   = 1'b1;
    bus.rd            = rd_i;
    bus.rs1           = rs1_i;
    bus.rs2           = rs2_i;
    bus.reg_wen       = !mw_i;
    bus.alu_src       = src_i;
    bus.imm           = imm_i;
    bus.alu_ctrl      = ctl_i;
    bus.mem_read      = mr_i;
    bus.mem_write     = mw_i;
    bus.data_type     = dt_i;
    bus.load_unsigned = lu_i;
    bus.jump_sel      = js_i;
    bus.new_pc        = pc_i;
    step();
    bus.issue_valid   = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.jump_sel      = 1'b0;
  endtask

  task automatic do_alu(input logic [4:0] rd_i, input logic [4:0] rs1_i,
                        input logic [31:0] imm_i, input logic [3:0] ctl_i);
    issue(rd_i, rs1_i, 5'd0, 1'b1, imm_i, ctl_i, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks += 8;
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%b exp=1", bus.issue_ready); end
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    if (bus.mem_be !== 4'b0000) begin failures++; $display("FAIL reset_mem_be got=%b exp=0000", bus.mem_be); end
    if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", misaligned); end
    if (eq !== 1'b0) begin failures++; $display("FAIL reset_eq got=%b exp=0", eq); end
    if (jalr_target !== 32'h0) begin failures++; $display("FAIL reset_jalr got=%h exp=0", jalr_target); end
    if (a0 !== 32'h0) begin failures++; $display("FAIL reset_a0 got=%h exp=0", a0); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_alu(5'd1, 5'd0, 32'd5, ADD);
    checks++;
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%b exp=1", bus.issue_ready); end
    do_alu(5'd2, 5'd1, 32'd3, ADD);
    checks++;
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1", bus.issue_ready); end
    do_alu(5'd10, 5'd2, 32'd0, ADD);
    step();
    checks++;
    if (a0 !== 32'd8) begin failures++; $display("FAIL b2b_x2 got=%h exp=00000008", a0); end
  endtask

  task automatic test_alu();
    logic [31:0] imms [14];
    logic [3:0]  ctls [14];
    logic [31:0] exps [14];
    imms = '{32'h10, 32'h10, 32'hFF, 32'h1, 32'hFFFFFFFF, 32'h4, 32'h4,
             32'h4, 32'h24, 32'h1, 32'h1, 32'h1234, 32'h5, 32'h5};
    ctls = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
             4'b0111, 4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1111, 4'b1011};
    exps = '{32'hF0000020, 32'hF0000000, 32'h00000010, 32'hF0000011, 32'h0FFFFFEF,
             32'h00000100, 32'h0F000001, 32'hFF000001, 32'h00000100, 32'h1,
             32'h0, 32'h1234, 32'h0, 32'h0};
    do_alu(5'd5, 5'd0, 32'hF0000010, ADD);
    for (int i = 0; i < 14; i++) begin
      do_alu(5'd10, 5'd5, imms[i], ctls[i]);
      step();
      checks++;
      if (a0 !== exps[i]) begin failures++; $display("FAIL alu_op%0d ctl=%b got=%h exp=%h", i, ctls[i], a0, exps[i]); end
    end
    do_alu(5'd6, 5'd0, 32'h10, ADD);
    issue(5'd10, 5'd5, 5'd6, 1'b0, 32'h0, 4'b0001, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (eq !== 1'b0) begin failures++; $display("FAIL eq_ne got=%b exp=0", eq); end
    step();
    checks++;
    if (a0 !== 32'hF0000000) begin failures++; $display("FAIL alu_reg_sub got=%h exp=f0000000", a0); end
    issue(5'd10, 5'd6, 5'd6, 1'b0, 32'h0, 4'b0100, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (eq !== 1'b1) begin failures++; $display("FAIL eq_eq got=%b exp=1", eq); end
  endtask

  task automatic test_store();
    int low;
    low = 0;
    do_alu(5'd3, 5'd0, 32'h100, ADD);
    do_alu(5'd4, 5'd0, 32'hAB, ADD);
    issue(5'd0, 5'd3, 5'd4, 1'b1, 32'h3, ADD, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    checks += 3;
    if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL st_we got=%b exp=1", bus.mem_we); end
    if (bus.mem_be !== 4'b1000) begin failures++; $display("FAIL st_be got=%b exp=1000", bus.mem_be); end
    if (bus.mem_wdata !== 32'hABABABAB) begin failures++; $display("FAIL st_wdata got=%h exp=abababab", bus.mem_wdata); end
    for (int c = 1; c <= 4; c++) begin
      checks += 2;
      if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL st_req_c%0d got=%b exp=1", c, bus.mem_req); end
      if (bus.mem_addr !== 32'h103) begin failures++; $display("FAIL st_addr_c%0d got=%h exp=00000103", c, bus.mem_addr); end
      bus.mem_ack = (c == 4);
      #1;
      if (!bus.issue_ready) low++;
      step();
      bus.mem_ack = 1'b0;
    end
    checks += 2;
    if (low !== 3) begin failures++; $display("FAIL st_stall_cycles got=%0d exp=3", low); end
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL st_req_after_ack got=%b exp=0", bus.mem_req); end
  endtask

  task automatic test_load();
    logic [31:0] exps [3];
    logic [31:0] rdat [3];
    logic [1:0]  dts  [3];
    logic        lus  [3];
    exps = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
    rdat = '{32'h00800000, 32'h00800000, 32'h80010000};
    dts  = '{2'b01, 2'b01, 2'b10};
    lus  = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(5'd10, 5'd3, 5'd0, 1'b1, 32'h2, ADD, 1'b1, 1'b0, dts[i], lus[i], 1'b0, 32'h0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdat[i];
      #1;
      checks += 3;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL ld%0d_req got=%b%b exp=10", i, bus.mem_req, bus.mem_we); end
      if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL ld%0d_ready got=%b exp=1", i, bus.issue_ready); end
      if (bus.mem_be !== (dts[i] == 2'b01 ? 4'b0100 : 4'b1100)) begin failures++; $display("FAIL ld%0d_be got=%b", i, bus.mem_be); end
      step();
      bus.mem_ack = 1'b0;
      checks++;
      if (a0 !== exps[i]) begin failures++; $display("FAIL ld%0d_data got=%h exp=%h", i, a0, exps[i]); end
    end
  endtask

  task automatic test_misaligned();
    issue(5'd10, 5'd3, 5'd0, 1'b1, 32'h1, ADD, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    checks += 3;
    if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", misaligned); end
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL mis_req got=%b exp=0", bus.mem_req); end
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL mis_ready got=%b exp=1", bus.issue_ready); end
    do_alu(5'd7, 5'd0, 32'h1, ADD);
    checks += 2;
    if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_one_cycle got=%b exp=0", misaligned); end
    if (a0 !== 32'hFFFF8001) begin failures++; $display("FAIL mis_rd_kept got=%h exp=ffff8001", a0); end
    do_alu(5'd10, 5'd7, 32'h0, ADD);
    step();
    checks++;
    if (a0 !== 32'h1) begin failures++; $display("FAIL mis_next_issue got=%h exp=00000001", a0); end
    issue(5'd0, 5'd3, 5'd4, 1'b1, 32'h1, ADD, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0);
    checks += 2;
    if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_sh_pulse got=%b exp=1", misaligned); end
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL mis_sh_req got=%b exp=0", bus.mem_req); end
    step();
  endtask

  task automatic test_jump();
    issue(5'd10, 5'd0, 5'd0, 1'b1, 32'h21, ADD, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h44);
    checks++;
    if (jalr_target !== 32'h20) begin failures++; $display("FAIL jalr_target got=%h exp=00000020", jalr_target); end
    step();
    checks++;
    if (a0 !== 32'h44) begin failures++; $display("FAIL jump_link got=%h exp=00000044", a0); end
  endtask

  task automatic test_reset_mid_request();
    issue(5'd10, 5'd3, 5'd0, 1'b1, 32'h0, ADD, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rstm_req_before got=%b exp=1", bus.mem_req); end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rstm_req got=%b exp=0", bus.mem_req); end
    if (bus.issue_ready !== 1'b1) begin failures++; $display("FAIL rstm_ready got=%b exp=1", bus.issue_ready); end
    if (a0 !== 32'h0) begin failures++; $display("FAIL rstm_a0 got=%h exp=0", a0); end
    if (jalr_target !== 32'h0) begin failures++; $display("FAIL rstm_jalr got=%h exp=0", jalr_target); end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    step();
    bus.mem_ack = 1'b0;
    checks += 2;
    if (a0 !== 32'h0) begin failures++; $display("FAIL rstm_late_ack got=%h exp=0", a0); end
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rstm_req_after got=%b exp=0", bus.mem_req); end
    do_alu(5'd10, 5'd3, 32'h7, ADD);
    step();
    checks++;
    if (a0 !== 32'h7) begin failures++; $display("FAIL rstm_x3_cleared got=%h exp=00000007", a0); end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    bus.issue_valid   = 1'b0;
    bus.rs1           = '0;
    bus.rs2           = '0;
    bus.rd            = '0;
    bus.reg_wen       = 1'b0;
    bus.alu_src       = 1'b0;
    bus.imm           = '0;
    bus.alu_ctrl      = '0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.data_type     = '0;
    bus.load_unsigned = 1'b0;
    bus.jump_sel      = 1'b0;
    bus.new_pc        = '0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    test_reset();
    test_back_to_back();
    test_alu();
    test_store();
    test_load();
    test_misaligned();
    test_jump();
    test_reset_mid_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
